bit_count_batcher: RTL
======================

# bit_count_batcher

Batch operand feeder that sits directly upstream of the bit-counting ASMD datapath. It buffers up to DEPTH bytes written by the host and drives them one at a time into the counter over its in/start/done handshake. It captures each 4-bit popcount, accumulates a batch total, and pulses batch_done when the whole buffer has been processed. Per-entry results stay readable until the next batch starts.

## Interface
- DEPTH, 8: number of buffered operand bytes (power of two, ≥2)
- AW, $clog2(DEPTH): buffer address width
- TW, $clog2(DEPTH*8+1): total width (7 for DEPTH=8)

- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- wr_en  in  1  write wr_data into buffer at slot count (honoured in IDLE only)
- wr_data  in  8  operand byte
- go  in  1  start batch (sampled in IDLE only)
- rd_addr  in  AW  readback index
- rd_result  out  4  combinational read of stored result[rd_addr]
- count  out  AW+1  number of bytes loaded
- overflow  out  1  sticky: write attempted while count==DEPTH; cleared by go or reset
- busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse at end of batch
- total  out  TW  sum of all results in last/current batch
- bc_in  out  8  operand to counter (registered)
- bc_start  out  1  counter start (registered)
- bc_result  in  4  counter result
- bc_done  in  1  counter done (registered in counter)

## Operation
- States: IDLE, SETUP, RUN, RELEASE, FINISH.
- IDLE: wr_en with count<DEPTH → buf[count]<=wr_data, count+1; count==DEPTH → write dropped, overflow<=1. go with count>0 → idx<=0, total<=0, result[] cleared, overflow<=0, → SETUP. go with count==0 → total<=0 → FINISH. go and wr_en in the same cycle: go wins; the write is dropped.
- SETUP (1 cycle): bc_in<=buf[idx], bc_start stays 0, so the counter samples the operand while in its idle state. → RUN.
- RUN: bc_start=1, bc_in held. On bc_done==1: result[idx]<=bc_result, total<=total+bc_result, bc_start<=0 → RELEASE.
- RELEASE: bc_start=0, bc_in held. Wait until bc_done==0 (counter back in idle). Then if idx==count-1 → FINISH, else idx+1 → SETUP.
- FINISH (1 cycle): batch_done=1, count<=0. Buffer contents are stale; results and total are retained. → IDLE.
- wr_en and go are ignored while busy. rd_addr may change at any time; rd_result never depends on state.
- Arithmetic: bc_result is zero-extended to TW bits. Overflow of total is impossible (≤8·DEPTH). idx wraps only via FINISH.
- Reset mid-batch: the next edge forces IDLE, bc_start=0, bc_in=0, count=0, total=0, results=0, overflow=0, batch_done=0. The counter then returns to its idle state on its own, because start is low.

## Timing
- Reset values: rd_result 0, count 0, overflow 0, busy 0, batch_done 0, total 0, bc_in 0x00, bc_start 0.
- go sampled at edge N → busy=1 and SETUP from N+1; bc_start rises at edge N+2.
- bc_start is never high in the same cycle that bc_in changes.
- bc_start falls on the edge after bc_done is seen high. The next SETUP is not entered until bc_done is seen low.
- Per byte: 1 (SETUP) + D (RUN until bc_done) + R (RELEASE until bc_done low, ≥1) cycles.
- batch_done pulses for exactly one cycle. busy drops on the following edge.
- total and result[] are updated on the same edge that bc_start falls.

## Test plan
- Reset then idle: hold reset 2 cycles → every output at its reset value; bc_start stays 0 for 20 cycles.
- Single byte: write 0x24, go; bench instantiates the bit counter → bc_in=0x24 one cycle before bc_start rises; rd_result[0]=2; total=2; one batch_done pulse; count=0 after.
- Full batch: write 0x24, 0xFF, 0x00, 0x81, 0x01, 0x80, 0x0F, 0xAA, go → results 2, 8, 0, 2, 1, 1, 4, 4; total=22; exactly 8 bc_start rising edges.
- Overflow and ignore: 9 writes → count=8, overflow=1. wr_en and go while busy → no effect on count or batch. Next go clears overflow.
- Empty go: go with count=0 → batch_done in 2 cycles, total=0, bc_start never high.
- Reset mid-batch: assert reset while in RUN on byte 3 → next edge IDLE, bc_start=0, total=0. A subsequent single-byte batch of 0xFF gives total=8.

Source files
------------

// File: rtl/bit_count_batcher.sv
// Batch feeder for the bit-counting datapath: buffers host bytes, drives them one
// by one over the start/done handshake, and keeps per-entry popcounts plus a total.
module bit_count_batcher #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int TW    = $clog2(DEPTH*8+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          go,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_result,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          batch_done,
  output logic [TW-1:0] total,
  output logic [7:0]    bc_in,
  output logic          bc_start,
  input  logic [3:0]    bc_result,
  input  logic          bc_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RUN     = 3'd2,
    RELEASE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          batch_done_q, batch_done_d;
  logic [TW-1:0] total_q, total_d;
  logic [7:0]    bc_in_q, bc_in_d;
  logic          bc_start_q, bc_start_d;
  logic [7:0]    buf_q    [DEPTH];
  logic [7:0]    buf_d    [DEPTH];
  logic [3:0]    result_q [DEPTH];
  logic [3:0]    result_d [DEPTH];
  logic [AW-1:0] idx_nxt_s;
  logic          last_s;

  assign idx_nxt_s = idx_q + {{(AW-1){1'b0}}, 1'b1};
  assign last_s    = ({1'b0, idx_q} == (count_q - ONE_CNT));

  // Next-state and datapath updates for the batch sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    batch_done_d = 1'b0;
    total_d      = total_q;
    bc_in_d      = bc_in_q;
    bc_start_d   = 1'b0;
    buf_d        = buf_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          overflow_d = 1'b0;
          total_d    = {TW{1'b0}};
          if (count_q != {(AW+1){1'b0}}) begin
            idx_d   = {AW{1'b0}};
            bc_in_d = buf_q[0];
            for (int i = 0; i < DEPTH; i++) begin
              result_d[i] = 4'd0;
            end
            state_d = SETUP;
          end else begin
            batch_done_d = 1'b1;
            state_d      = FINISH;
          end
        end else if (wr_en) begin
          if (count_q == FULL_CNT) begin
            overflow_d = 1'b1;
          end else begin
            buf_d[count_q[AW-1:0]] = wr_data;
            count_d                = count_q + ONE_CNT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        // Operand has been stable for this whole cycle; start goes up next edge.
        bc_start_d = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (bc_done) begin
          result_d[idx_q] = bc_result;
          total_d         = total_q + {{(TW-4){1'b0}}, bc_result};
          bc_start_d      = 1'b0;
          state_d         = RELEASE;
        end else begin
          bc_start_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!bc_done) begin
          if (last_s) begin
            batch_done_d = 1'b1;
            state_d      = FINISH;
          end else begin
            idx_d   = idx_nxt_s;
            bc_in_d = buf_q[idx_nxt_s];
            state_d = SETUP;
          end
        end else begin
          state_d = RELEASE;
        end
      end
      FINISH: begin
        count_d = {(AW+1){1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= {AW{1'b0}};
      count_q      <= {(AW+1){1'b0}};
      overflow_q   <= 1'b0;
      batch_done_q <= 1'b0;
      total_q      <= {TW{1'b0}};
      bc_in_q      <= 8'h00;
      bc_start_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i]    <= 8'h00;
        result_q[i] <= 4'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      batch_done_q <= batch_done_d;
      total_q      <= total_d;
      bc_in_q      <= bc_in_d;
      bc_start_q   <= bc_start_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i]    <= buf_d[i];
        result_q[i] <= result_d[i];
      end
    end
  end

  assign rd_result  = result_q[rd_addr];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);
  assign batch_done = batch_done_q;
  assign total      = total_q;
  assign bc_in      = bc_in_q;
  assign bc_start   = bc_start_q;

endmodule
